// File: rtl/subservient_dbg_loader.sv
// Streams bytes into subservient SRAM over the Wishbone debug port, packing
// them little-endian into words while holding the core in debug mode.
module subservient_dbg_loader #(
  parameter int memsize = 8192,
  parameter int aw      = $clog2(memsize)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [7:0]    i_tdata,
  input  logic          i_tvalid,
  output logic          o_tready,
  input  logic          i_tlast,
  output logic          o_debug_mode,
  output logic [31:0]   o_wb_dbg_adr,
  output logic [31:0]   o_wb_dbg_dat,
  output logic [3:0]    o_wb_dbg_sel,
  output logic          o_wb_dbg_we,
  output logic          o_wb_dbg_stb,
  input  logic          i_wb_dbg_ack,
  output logic          o_done,
  output logic          o_err,
  output logic [aw:0]   o_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [aw:0] MEM_LIMIT   = (aw + 1)'(memsize);
  localparam logic [3:0]  SETTLE_LAST = 4'd9;

  state_t      state, state_nxt;
  logic        last_word;
  logic [3:0]  settle_cnt;
  logic        take;
  logic        full;
  logic        flush;
  logic [1:0]  lane;

  assign o_tready     = (state == S_LOAD);
  assign o_wb_dbg_sel = 4'b1111;
  assign o_wb_dbg_we  = o_wb_dbg_stb;

  assign take  = i_tvalid & o_tready;
  assign full  = (o_count == MEM_LIMIT);
  assign lane  = o_count[1:0];
  // A word goes out when its top lane fills or the image ends mid-word.
  assign flush = take & ~full & ((lane == 2'd3) | i_tlast);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every combinationally written signal gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (i_start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (flush)                      state_nxt = S_WRITE;
        else if (take & full & i_tlast) state_nxt = S_SETTLE;
      end
      S_WRITE:  if (i_wb_dbg_ack) state_nxt = last_word ? S_SETTLE : S_LOAD;
      S_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = S_DONE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_debug_mode <= 1'b0;
      o_wb_dbg_adr <= '0;
      o_wb_dbg_dat <= '0;
      o_wb_dbg_stb <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_count      <= '0;
      last_word    <= 1'b0;
      settle_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            o_count      <= '0;
            o_err        <= 1'b0;
            o_done       <= 1'b0;
            o_debug_mode <= 1'b1;
          end
        end
        S_LOAD: begin
          settle_cnt <= '0;
          if (take) begin
            if (full) begin
              o_err <= 1'b1;
            end else begin
              o_count <= o_count + 1'b1;
              // Lane 0 starts a fresh word, which keeps the unwritten upper lanes zero.
              if (lane == 2'd0) o_wb_dbg_dat <= {24'h0, i_tdata};
              else              o_wb_dbg_dat[{lane, 3'b000} +: 8] <= i_tdata;
              if (flush) begin
                o_wb_dbg_adr <= {{(31 - aw){1'b0}}, o_count[aw:2], 2'b00};
                o_wb_dbg_stb <= 1'b1;
                last_word    <= i_tlast;
              end
            end
          end
        end
        S_WRITE: begin
          settle_cnt <= '0;
          if (i_wb_dbg_ack) o_wb_dbg_stb <= 1'b0;
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            o_debug_mode <= 1'b0;
            o_done       <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subservient_dbg_loader.sv
// Scoreboard bench for subservient_dbg_loader: a default-size instance and a
// 16-byte instance share one stimulus path selected by use_small.
module tb_subservient_dbg_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, tvalid = 1'b0, tlast = 1'b0, ack = 1'b0, use_small = 1'b0;
  logic [7:0] tdata = 8'h00;

  logic        tready_b, dbg_b, we_b, stb_b, done_b, err_b;
  logic [31:0] adr_b, dat_b;
  logic [3:0]  sel_b;
  logic [13:0] count_b;

  logic        tready_s, dbg_s, we_s, stb_s, done_s, err_s;
  logic [31:0] adr_s, dat_s;
  logic [3:0]  sel_s;
  logic [4:0]  count_s;

  subservient_dbg_loader dut_big (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start & ~use_small),
    .i_tdata(tdata), .i_tvalid(tvalid & ~use_small), .o_tready(tready_b),
    .i_tlast(tlast), .o_debug_mode(dbg_b), .o_wb_dbg_adr(adr_b),
    .o_wb_dbg_dat(dat_b), .o_wb_dbg_sel(sel_b), .o_wb_dbg_we(we_b),
    .o_wb_dbg_stb(stb_b), .i_wb_dbg_ack(ack & ~use_small), .o_done(done_b),
    .o_err(err_b), .o_count(count_b)
  );

  subservient_dbg_loader #(.memsize(16)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start & use_small),
    .i_tdata(tdata), .i_tvalid(tvalid & use_small), .o_tready(tready_s),
    .i_tlast(tlast), .o_debug_mode(dbg_s), .o_wb_dbg_adr(adr_s),
    .o_wb_dbg_dat(dat_s), .o_wb_dbg_sel(sel_s), .o_wb_dbg_we(we_s),
    .o_wb_dbg_stb(stb_s), .i_wb_dbg_ack(ack & use_small), .o_done(done_s),
    .o_err(err_s), .o_count(count_s)
  );

  // View of whichever instance is currently selected.
  logic        tready, dbg, we, stb, done, err;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic [13:0] count_v;
  assign tready  = use_small ? tready_s : tready_b;
  assign dbg     = use_small ? dbg_s    : dbg_b;
  assign we      = use_small ? we_s     : we_b;
  assign stb     = use_small ? stb_s    : stb_b;
  assign done    = use_small ? done_s   : done_b;
  assign err     = use_small ? err_s    : err_b;
  assign adr     = use_small ? adr_s    : adr_b;
  assign dat     = use_small ? dat_s    : dat_b;
  assign sel     = use_small ? sel_s    : sel_b;
  assign count_v = use_small ? 14'(count_s) : count_b;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t  exp_q[$];
  int   ack_delay = 1;
  logic ack_en = 1'b1;
  int   wait_cnt = 0;
  int   cyc = 0;
  int   last_ack_edge = 0;
  int   last_take_edge = 0;

  always @(posedge clk) cyc++;

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.adr = a;
    w.dat = d;
    exp_q.push_back(w);
  endtask

  // Monitor and ack responder: checks every strobe cycle against the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack = 1'b0;
      wait_cnt = 0;
    end else if (ack) begin
      ack = 1'b0;
      check("stb_drop_after_ack", stb, 0);
    end else if (stb) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got adr %h dat %h, expected no write", adr, dat);
      end else begin
        check("wb_adr", adr, exp_q[0].adr);
        check("wb_dat", dat, exp_q[0].dat);
        check("wb_sel", sel, 32'hF);
        check("wb_we", we, 1);
        check("tready_during_write", tready, 0);
        if (ack_en && wait_cnt >= ack_delay) begin
          ack = 1'b1;
          last_ack_edge = cyc + 1;
          void'(exp_q.pop_front());
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("dbg_after_start", dbg, 1);
    check("tready_after_start", tready, 1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t = 0;
    tdata = d; tvalid = 1'b1; tlast = l;
    @(negedge clk);
    while (!tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL byte_timeout: got tready 0 for byte %h, expected 1", d);
    end
    @(posedge clk); #1;
    last_take_edge = cyc;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_run(input logic [7:0] first, input int n, input logic last_on_end);
    for (int i = 0; i < n; i++)
      send_byte(first + 8'(i), last_on_end && (i == n - 1));
  endtask

  task automatic wait_done(input logic [13:0] exp_count, input logic exp_err);
    int t = 0;
    int ref_edge;
    @(negedge clk);
    while (!done && t < 500) begin
      @(negedge clk);
      t++;
    end
    ref_edge = (last_ack_edge > last_take_edge) ? last_ack_edge : last_take_edge;
    check("done_set", done, 1);
    check("settle_cycles", 32'(cyc - ref_edge), 10);
    check("dbg_released", dbg, 0);
    check("count_final", count_v, exp_count);
    check("err_final", err, exp_err);
    check("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int t;
    #3;
    check("rst_stb", stb, 0);
    check("rst_we", we, 0);
    check("rst_dbg", dbg, 0);
    check("rst_tready", tready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", count_v, 0);
    check("rst_adr", adr, 0);
    check("rst_dat", dat, 0);
    check("rst_sel", sel, 32'hF);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Eight bytes, ack one cycle into each strobe.
    ack_delay = 1;
    do_start();
    push_exp(32'h0, 32'h03020100);
    push_exp(32'h4, 32'h07060504);
    send_run(8'h00, 8, 1'b1);
    wait_done(14'd8, 1'b0);

    // Partial final word is zero padded.
    @(posedge clk); #1;
    do_start();
    push_exp(32'h0, 32'hDDCCBBAA);
    push_exp(32'h4, 32'h000000EE);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0); send_byte(8'hEE, 1'b1);
    wait_done(14'd5, 1'b0);

    // Slow ack with the stream pushing continuously.
    ack_delay = 7;
    @(posedge clk); #1;
    do_start();
    push_exp(32'h0, 32'h13121110);
    push_exp(32'h4, 32'h17161514);
    push_exp(32'h8, 32'h1B1A1918);
    send_run(8'h10, 12, 1'b1);
    wait_done(14'd12, 1'b0);

    // Overflow on the 16-byte instance, ack in the first strobe cycle.
    ack_delay = 0;
    use_small = 1'b1;
    @(posedge clk); #1;
    do_start();
    push_exp(32'h0, 32'h23222120);
    push_exp(32'h4, 32'h27262524);
    push_exp(32'h8, 32'h2B2A2928);
    push_exp(32'hC, 32'h2F2E2D2C);
    send_run(8'h20, 20, 1'b1);
    wait_done(14'd16, 1'b1);

    // Restart from DONE clears the sticky flags.
    @(posedge clk); #1;
    do_start();
    check("restart_done_clr", done, 0);
    check("restart_err_clr", err, 0);
    check("restart_count_clr", count_v, 0);
    push_exp(32'h0, 32'h44434241);
    send_run(8'h41, 4, 1'b1);
    wait_done(14'd4, 1'b0);
    use_small = 1'b0;

    // Reset in the middle of a write cycle.
    ack_en = 1'b0;
    ack_delay = 1;
    @(posedge clk); #1;
    do_start();
    push_exp(32'h0, 32'h53525150);
    send_run(8'h50, 4, 1'b0);
    t = 0;
    while (!stb && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("stb_before_reset", stb, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_stb", stb, 0);
    check("async_rst_dbg", dbg, 0);
    check("async_rst_tready", tready, 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    ack_en = 1'b1;
    @(posedge clk); #1;
    do_start();
    push_exp(32'h0, 32'h63626160);
    send_run(8'h60, 4, 1'b1);
    wait_done(14'd4, 1'b0);

    // Start pulse during LOAD is ignored.
    @(posedge clk); #1;
    do_start();
    push_exp(32'h0, 32'h73727170);
    push_exp(32'h4, 32'h00007574);
    send_run(8'h70, 2, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignored_start_count", count_v, 2);
    check("ignored_start_tready", tready, 1);
    send_run(8'h72, 4, 1'b1);
    wait_done(14'd6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/subservient_dbg_loader.md
# subservient_dbg_loader

Hardware firmware loader for the subservient SoC. It accepts a byte stream from a UART receiver, SPI flash reader or similar, packs the bytes into little-endian 32-bit words, and writes them into SRAM through the subservient Wishbone debug port. While a load runs it holds the SoC in debug mode, and it releases the core once the image is written. It replaces the bench-side debug-write sequencer with synthesizable logic, so silicon and FPGA builds can boot from an external byte source.

## Interface
Parameters:
- memsize, 8192, SRAM size in bytes; bytes beyond it are discarded.
- aw, $clog2(memsize), SRAM byte-address width.

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  reset; asynchronous assert, active-low
- i_start  in  1  begin a load; sampled only in IDLE or DONE
- i_tdata  in  8  stream byte
- i_tvalid  in  1  stream byte valid
- o_tready  out  1  loader accepts a byte this cycle
- i_tlast  in  1  qualifies the final byte of the image
- o_debug_mode  out  1  to subservient i_debug_mode
- o_wb_dbg_adr  out  32  byte address, word aligned
- o_wb_dbg_dat  out  32  write data
- o_wb_dbg_sel  out  4  byte select; always 4'b1111
- o_wb_dbg_we  out  1  always 1 while a cycle is active
- o_wb_dbg_stb  out  1  Wishbone strobe (cyc implied)
- i_wb_dbg_ack  in  1  Wishbone acknowledge
- o_done  out  1  load complete; debug mode released
- o_err  out  1  sticky; image exceeded memsize
- o_count  out  aw+1  bytes accepted and stored

## Operation
- States:
  - IDLE: o_tready=0.
  - LOAD: o_tready=1.
  - WRITE: o_wb_dbg_stb=1, o_tready=0.
  - SETTLE: 10-cycle guard.
  - DONE: o_done=1.
- Transitions:
  - IDLE or DONE, on i_start: go to LOAD. Clear o_count, o_err and o_done. Set o_debug_mode=1.
  - LOAD, on handshake (i_tvalid&o_tready): store i_tdata in lane o_count[1:0] of the word buffer, then o_count++.
    - If that lane was 3, or i_tlast=1: latch adr = {o_count[aw:2],2'b00} (pre-increment count). Zero the lanes above the written lane. Go to WRITE and remember whether this word carries i_tlast.
  - WRITE, on i_wb_dbg_ack: go to SETTLE if this was the last word, else to LOAD.
  - SETTLE: count 10 cycles, then set o_debug_mode=0 and go to DONE.
  - DONE: hold until i_start.
- Overflow: a handshake with o_count==memsize sets o_err. The byte is consumed and dropped, o_count saturates, and no Wishbone write is issued. i_tlast still ends the load through SETTLE. A buffered partial word is flushed first.
- i_start is ignored in LOAD, WRITE and SETTLE.
- o_wb_dbg_adr and o_wb_dbg_dat are stable for the whole strobe. o_wb_dbg_we equals o_wb_dbg_stb.

## Timing
- Reset values: state=IDLE, o_debug_mode=0, o_tready=0, o_wb_dbg_stb=0, o_wb_dbg_we=0, o_wb_dbg_adr=0, o_wb_dbg_dat=0, o_wb_dbg_sel=4'b1111, o_done=0, o_err=0, o_count=0.
- Reset mid-load aborts immediately with no flush. SRAM contents are undefined.
- All outputs are registered except o_tready, which decodes state (LOAD) combinationally.
- i_start sampled high at edge N: o_debug_mode=1 and o_tready=1 from cycle N+1.
- The 4th byte (or the i_tlast byte) accepted at edge N: o_wb_dbg_stb=1 from cycle N+1. o_tready=0 during the strobe.
- i_wb_dbg_ack high at edge M: o_wb_dbg_stb=0 from cycle M+1.
  - Ack in the first strobe cycle is legal.
  - Ack while stb=0 is ignored.
- Best-case throughput: 4 bytes per 5 cycles with single-cycle ack.
- Last ack at edge M: o_debug_mode=0 and o_done=1 from cycle M+11.

## Test plan
- 8 bytes 00..07, i_tlast on 07, ack 1 cycle after stb -> writes (0x0,0x03020100) then (0x4,0x07060504). o_count=8, o_done=1 after 10 guard cycles, o_debug_mode falls.
- 5 bytes AA BB CC DD EE, i_tlast on EE -> second write is (0x4,0x000000EE) with sel=4'b1111. o_count=5.
- Ack delayed 7 cycles with i_tvalid held high -> o_tready=0 throughout. Adr and dat stable. No byte lost. Stb drops the cycle after ack.
- memsize=16, 20-byte image -> 4 writes only (last adr 0xC). o_err=1, o_count=16, o_done=1.
- i_rst_n pulsed low mid-WRITE -> stb, debug_mode and tready go to 0 asynchronously. A fresh i_start reloads from adr 0.
- i_start pulsed during LOAD -> ignored. Load completes normally. A second i_start from DONE clears o_done and o_err and restarts.
